// File: rtl/dma_mem_port_arb.sv
// dma_mem_port_arb: single-port SRAM arbiter shared by one lane's DMA
// write/read channels and the PE load/store path.
// Load/store takes exclusive ownership through request/grant/release. While
// the DMA owns the port, its write and read channels alternate round-robin.
// Read returns are tagged with their owner in an RD_LAT-deep pipe, and every
// ownership change waits for that pipe to drain.
// Optional: define DMA_MEM_PORT_ARB_STATS_EN to add saturating grant and
// stall counters together with their output ports.
module dma_mem_port_arb #(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              reset_poweron,
   input  logic              dma__memc__write_valid,
   input  logic [ADDR_W-1:0] dma__memc__write_address,
   input  logic [DATA_W-1:0] dma__memc__write_data,
   output logic              memc__dma__write_ready,
   input  logic              dma__memc__read_valid,
   input  logic [ADDR_W-1:0] dma__memc__read_address,
   input  logic              dma__memc__read_pause,
   output logic              memc__dma__read_ready,
   output logic [DATA_W-1:0] memc__dma__read_data,
   output logic              memc__dma__read_data_valid,
   input  logic              ldst__memc__request,
   input  logic              ldst__memc__released,
   output logic              memc__ldst__granted,
   input  logic              ldst__memc__write_valid,
   input  logic [ADDR_W-1:0] ldst__memc__write_address,
   input  logic [DATA_W-1:0] ldst__memc__write_data,
   input  logic              ldst__memc__read_valid,
   input  logic [ADDR_W-1:0] ldst__memc__read_address,
   output logic [DATA_W-1:0] memc__ldst__read_data,
   output logic              memc__ldst__read_data_valid,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
`ifdef DMA_MEM_PORT_ARB_STATS_EN
   ,
   output logic [31:0]       stat_dma_wr_cnt,
   output logic [31:0]       stat_dma_rd_cnt,
   output logic [31:0]       stat_ldst_stall_cnt
`endif
);

   typedef enum logic [1:0] {DMA_OWN, DRAIN_IN, LDST_OWN, DRAIN_OUT} state_t;

   state_t            state, state_nxt;
   logic              rr_last, rr_last_nxt;   // 1: the read side won the last contention
   logic [RD_LAT:1]   vld_pipe, own_pipe;     // own = 1 marks a load/store read
   logic              pipe_empty;
   logic              issue_rd, issue_own;
   logic              wr_cand, rd_cand;
   logic              dma_ret, ldst_ret;
   logic [DATA_W-1:0] dma_hold, ldst_hold;

   assign pipe_empty = ~|vld_pipe;

   // State, round-robin pointer and read-tag pipe
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         state    <= DMA_OWN;
         rr_last  <= 1'b1;
         vld_pipe <= '0;
         own_pipe <= '0;
      end else begin
         state       <= state_nxt;
         rr_last     <= rr_last_nxt;
         vld_pipe[1] <= issue_rd;
         own_pipe[1] <= issue_own;
         for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            own_pipe[i] <= own_pipe[i-1];
         end
      end
   end

   // Next state, issue selection and the combinational SRAM drive
   always_comb begin
      state_nxt              = state;
      rr_last_nxt            = rr_last;
      memc__dma__write_ready = 1'b0;
      memc__dma__read_ready  = 1'b0;
      sram_en                = 1'b0;
      sram_we                = 1'b0;
      sram_addr              = '0;
      sram_wdata             = '0;
      issue_rd               = 1'b0;
      issue_own              = 1'b0;
      wr_cand                = dma__memc__write_valid;
      rd_cand                = dma__memc__read_valid & ~dma__memc__read_pause;
      // Reset also gates issue so that every output reads 0 during reset
      if (reset_poweron) begin
         case (state)
            DMA_OWN: begin
               if (ldst__memc__request) begin
                  // Load/store wins even against a pending DMA access
                  state_nxt = DRAIN_IN;
               end else begin
                  if (wr_cand && rd_cand) begin
                     if (rr_last) rd_cand = 1'b0;
                     else         wr_cand = 1'b0;
                     rr_last_nxt = rd_cand;
                  end
                  if (wr_cand) begin
                     memc__dma__write_ready = 1'b1;
                     sram_en    = 1'b1;
                     sram_we    = 1'b1;
                     sram_addr  = dma__memc__write_address;
                     sram_wdata = dma__memc__write_data;
                  end else if (rd_cand) begin
                     memc__dma__read_ready = 1'b1;
                     sram_en   = 1'b1;
                     sram_addr = dma__memc__read_address;
                     issue_rd  = 1'b1;
                  end
               end
            end
            DRAIN_IN: begin
               if (pipe_empty) state_nxt = LDST_OWN;
            end
            LDST_OWN: begin
               // A write presented together with a read wins; the read is dropped
               if (ldst__memc__write_valid) begin
                  sram_en    = 1'b1;
                  sram_we    = 1'b1;
                  sram_addr  = ldst__memc__write_address;
                  sram_wdata = ldst__memc__write_data;
               end else if (ldst__memc__read_valid) begin
                  sram_en   = 1'b1;
                  sram_addr = ldst__memc__read_address;
                  issue_rd  = 1'b1;
                  issue_own = 1'b1;
               end
               if (ldst__memc__released || !ldst__memc__request) state_nxt = DRAIN_OUT;
            end
            default: begin
               if (pipe_empty) state_nxt = DMA_OWN;
            end
         endcase
      end
   end

   assign memc__ldst__granted = (state == LDST_OWN);

   assign dma_ret  = vld_pipe[RD_LAT] & ~own_pipe[RD_LAT];
   assign ldst_ret = vld_pipe[RD_LAT] &  own_pipe[RD_LAT];

   assign memc__dma__read_data_valid  = dma_ret;
   assign memc__ldst__read_data_valid = ldst_ret;
   assign memc__dma__read_data        = dma_ret  ? sram_rdata : dma_hold;
   assign memc__ldst__read_data       = ldst_ret ? sram_rdata : ldst_hold;

   // Each return data output keeps its last delivered word while idle
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         dma_hold  <= '0;
         ldst_hold <= '0;
      end else begin
         if (dma_ret)  dma_hold  <= sram_rdata;
         if (ldst_ret) ldst_hold <= sram_rdata;
      end
   end

`ifdef DMA_MEM_PORT_ARB_STATS_EN
   // Saturating grant and ownership-drain stall counters
   always_ff @(posedge clk or negedge reset_poweron) begin
      if (!reset_poweron) begin
         stat_dma_wr_cnt     <= '0;
         stat_dma_rd_cnt     <= '0;
         stat_ldst_stall_cnt <= '0;
      end else begin
         if (memc__dma__write_ready && stat_dma_wr_cnt != 32'hFFFF_FFFF)
            stat_dma_wr_cnt <= stat_dma_wr_cnt + 32'd1;
         if (memc__dma__read_ready && stat_dma_rd_cnt != 32'hFFFF_FFFF)
            stat_dma_rd_cnt <= stat_dma_rd_cnt + 32'd1;
         if ((state == DRAIN_IN || state == DRAIN_OUT) && stat_ldst_stall_cnt != 32'hFFFF_FFFF)
            stat_ldst_stall_cnt <= stat_ldst_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dma_mem_port_arb.sv
// Self-checking bench for dma_mem_port_arb. An ownership-mode model with a
// queue of in-flight reads, each tagged with its due cycle, predicts every
// output on every cycle. Directed sequences pin the model to literal values,
// and a long randomized run follows them.
module tb_dma_mem_port_arb;
   localparam int AW = 24, DW = 32, LAT = 2;
   localparam int M_DMA = 0, M_DIN = 1, M_LDST = 2, M_DOUT = 3;

   logic clk = 1'b0, rst_n = 1'b0;
   logic dwv, drv, dpause, lreq, lrel, lwv, lrv;
   logic [AW-1:0] dwa, dra, lwa, lra;
   logic [DW-1:0] dwd, lwd, srd;
   logic o_wrdy, o_rrdy, o_dv, o_gr, o_lv, o_en, o_we;
   logic [DW-1:0] o_dd, o_ld, o_wd;
   logic [AW-1:0] o_addr;

   dma_mem_port_arb #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
      .clk(clk), .reset_poweron(rst_n),
      .dma__memc__write_valid(dwv), .dma__memc__write_address(dwa), .dma__memc__write_data(dwd),
      .memc__dma__write_ready(o_wrdy),
      .dma__memc__read_valid(drv), .dma__memc__read_address(dra), .dma__memc__read_pause(dpause),
      .memc__dma__read_ready(o_rrdy), .memc__dma__read_data(o_dd), .memc__dma__read_data_valid(o_dv),
      .ldst__memc__request(lreq), .ldst__memc__released(lrel), .memc__ldst__granted(o_gr),
      .ldst__memc__write_valid(lwv), .ldst__memc__write_address(lwa), .ldst__memc__write_data(lwd),
      .ldst__memc__read_valid(lrv), .ldst__memc__read_address(lra),
      .memc__ldst__read_data(o_ld), .memc__ldst__read_data_valid(o_lv),
      .sram_en(o_en), .sram_we(o_we), .sram_addr(o_addr), .sram_wdata(o_wd), .sram_rdata(srd));

   always #5 clk = ~clk;

   typedef struct {int due; bit ldst; logic [DW-1:0] data;} rd_t;
   rd_t q[$];
   int mode, cyc, checks, fails;
   bit rr_rd_last;
   logic [DW-1:0] dma_hold, ldst_hold;
   // values seen in the most recent step, used by the literal pins
   logic s_wrdy, s_rrdy, s_dv, s_gr, s_lv, s_en, s_we;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wd, s_ld;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic idle_in();
      dwv = 0; drv = 0; dpause = 0; lreq = 0; lrel = 0; lwv = 0; lrv = 0;
      dwa = '0; dra = '0; lwa = '0; lra = '0; dwd = '0; lwd = '0;
   endtask

   // One clock: drive sram_rdata, compare at the falling edge, advance the model
   task automatic step();
      bit due, w, r, pe, e_wrdy, e_rrdy, e_dv, e_lv, e_en, e_we, rd_iss, rd_own;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_dd, e_ld;
      int nmode;
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      due = q.size() > 0 && q[0].due == cyc;
      srd = due ? q[0].data : $urandom;
      #4;
      {e_wrdy, e_rrdy, e_dv, e_lv, e_en, e_we, rd_iss, rd_own} = '0;
      e_addr = '0; e_wd = '0;
      nmode = mode;
      if (!rst_n) begin
         mode = M_DMA; nmode = M_DMA; rr_rd_last = 1; q.delete();
         dma_hold = '0; ldst_hold = '0;
      end else begin
         pe = (q.size() == 0);
         if (due) begin
            if (q[0].ldst) e_lv = 1; else e_dv = 1;
         end
         case (mode)
            M_DMA: if (lreq) nmode = M_DIN;
                   else begin
                      w = dwv; r = drv && !dpause;
                      if (w && r) begin
                         if (rr_rd_last) r = 0; else w = 0;
                         rr_rd_last = r;
                      end
                      if (w) begin e_wrdy = 1; e_en = 1; e_we = 1; e_addr = dwa; e_wd = dwd; end
                      else if (r) begin e_rrdy = 1; e_en = 1; e_addr = dra; rd_iss = 1; end
                   end
            M_DIN: if (pe) nmode = M_LDST;
            M_LDST: begin
               if (lwv) begin e_en = 1; e_we = 1; e_addr = lwa; e_wd = lwd; end
               else if (lrv) begin e_en = 1; e_addr = lra; rd_iss = 1; rd_own = 1; end
               if (lrel || !lreq) nmode = M_DOUT;
            end
            default: if (pe) nmode = M_DMA;
         endcase
      end
      e_dd = e_dv ? srd : dma_hold;
      e_ld = e_lv ? srd : ldst_hold;
      chk("write_ready", o_wrdy, e_wrdy);
      chk("read_ready", o_rrdy, e_rrdy);
      chk("granted", o_gr, rst_n && mode == M_LDST);
      chk("dma_valid", o_dv, e_dv);
      chk("dma_data", o_dd, e_dd);
      chk("ldst_valid", o_lv, e_lv);
      chk("ldst_data", o_ld, e_ld);
      chk("sram_en", o_en, e_en);
      chk("sram_we", o_we, e_we);
      if (e_en) chk("sram_addr", o_addr, e_addr);
      if (e_we) chk("sram_wdata", o_wd, e_wd);
      {s_wrdy, s_rrdy, s_dv, s_gr, s_lv, s_en, s_we} = {o_wrdy, o_rrdy, o_dv, o_gr, o_lv, o_en, o_we};
      s_addr = o_addr; s_wd = o_wd; s_ld = o_ld;
      if (rd_iss) q.push_back('{due: cyc + LAT, ldst: rd_own, data: $urandom});
      dma_hold = e_dd; ldst_hold = e_ld;
      mode = nmode;
      @(posedge clk); #1;
      cyc++;
   endtask

   initial begin
      checks = 0; fails = 0; cyc = 0; mode = M_DMA; rr_rd_last = 1;
      dma_hold = '0; ldst_hold = '0;
      idle_in(); srd = '0;
      #1;
      repeat (3) step();
      chk("reset_granted", s_gr, 0);
      chk("reset_en", s_en, 0);
      rst_n = 1;

      // lone DMA write goes straight to the SRAM in the same cycle
      dwv = 1; dwa = 24'h000010; dwd = 32'hDEADBEEF;
      step();
      chk("pin_wr_ready", s_wrdy, 1);
      chk("pin_wr_we", s_we, 1);
      chk("pin_wr_addr", s_addr, 24'h10);
      chk("pin_wr_data", s_wd, 32'hDEADBEEF);

      // write and read both valid: W,R,W,R,W,R, each read returns 2 cycles later
      for (int i = 0; i < 8; i++) begin
         dwv = (i < 6); drv = (i < 6); dwa = 24'h100 + i; dra = 24'h200 + i; dwd = $urandom;
         step();
         chk("pin_alt_w", s_wrdy, (i < 6) && (i % 2 == 0));
         chk("pin_alt_r", s_rrdy, (i < 6) && (i % 2 == 1));
         chk("pin_alt_ret", s_dv, (i == 3 || i == 5 || i == 7));
      end
      idle_in();

      // two DMA reads in flight, then load/store requests the port
      drv = 1; dra = 24'h300; step(); dra = 24'h301; step();
      drv = 1; lreq = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("pin_drain_no_grant", s_rrdy, 0);
         chk("pin_drain_gr", s_gr, 0);
      end
      drv = 0; lrv = 1; lra = 24'h20;
      step();
      chk("pin_ldst_gr", s_gr, 1);
      chk("pin_ldst_rd_addr", s_addr, 24'h20);
      lrv = 0; step(); step();
      chk("pin_ldst_ret", s_lv, 1);

      // release with a load/store read in flight
      lrv = 1; lra = 24'h40; lrel = 1; dwv = 1; dwa = 24'h50;
      step();
      lrv = 0; lrel = 0; lreq = 0;
      step();
      chk("pin_rel_gr", s_gr, 0);
      chk("pin_rel_no_wr", s_wrdy, 0);
      step();
      chk("pin_rel_ret", s_lv, 1);
      chk("pin_rel_no_wr2", s_wrdy, 0);
      step(); step();
      chk("pin_rel_resume", s_wrdy, 1);
      idle_in();

      // read_pause blocks reads but not writes
      drv = 1; dra = 24'h60; step();
      dpause = 1; dwv = 1;
      for (int i = 0; i < 5; i++) begin
         dwa = 24'h70 + i; step();
         chk("pin_pause_rrdy", s_rrdy, 0);
         chk("pin_pause_wrdy", s_wrdy, 1);
         if (i == 1) chk("pin_pause_ret", s_dv, 1);
      end
      idle_in();

      // reset with one read in flight
      drv = 1; dra = 24'h80; step(); drv = 0;
      rst_n = 0; step();
      chk("pin_rst_en", s_en, 0);
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin step(); chk("pin_rst_nostray", s_dv, 0); end
      dwv = 1; drv = 1; step();
      chk("pin_rst_wprio", s_wrdy, 1);
      idle_in();

      // randomized traffic with ownership churn and occasional reset
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 39) == 0) lreq = !lreq;
         lrel   = lreq && ($urandom_range(0, 15) == 0);
         dwv    = $urandom_range(0, 2) != 0;
         drv    = $urandom_range(0, 2) != 0;
         dpause = $urandom_range(0, 3) == 0;
         lwv    = $urandom_range(0, 2) == 0;
         lrv    = $urandom_range(0, 1) == 0;
         dwa = AW'($urandom); dra = AW'($urandom); lwa = AW'($urandom); lra = AW'($urandom);
         dwd = $urandom; lwd = $urandom;
         if ($urandom_range(0, 599) == 0) rst_n = 0;
         else rst_n = 1;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule

// File: doc/dma_mem_port_arb.md
Name: dma_mem_port_arb

Overview:
- Single-port memory access arbiter directly downstream of each lane's DMA controller.
- Consumes the DMA write/read channel (dma__memc__* / memc__dma__*) and the per-PE SIMD load/store channel (ldst__memc__*).
- Multiplexes both onto one synchronous SRAM port.
- The load/store path gains exclusive ownership through a request/grant/release handshake; otherwise the DMA channels share the port round-robin.

Parameters:
ADDR_W, 24, word address width
DATA_W, 32, data width
RD_LAT, 2, SRAM read latency in cycles (1..4)

Ports:
clk  input  1  system clock
reset_poweron  input  1  asynchronous, active-low reset
dma__memc__write_valid  input  1  DMA write request
dma__memc__write_address  input  ADDR_W  DMA write address
dma__memc__write_data  input  DATA_W  DMA write data
memc__dma__write_ready  output  1  DMA write accepted this cycle
dma__memc__read_valid  input  1  DMA read request
dma__memc__read_address  input  ADDR_W  DMA read address
dma__memc__read_pause  input  1  DMA back-pressure; blocks new read issue
memc__dma__read_ready  output  1  DMA read accepted this cycle
memc__dma__read_data  output  DATA_W  DMA read return data
memc__dma__read_data_valid  output  1  DMA read return valid
ldst__memc__request  input  1  load/store ownership request (level)
ldst__memc__released  input  1  load/store release pulse
memc__ldst__granted  output  1  load/store owns the port
ldst__memc__write_valid  input  1  load/store write
ldst__memc__write_address  input  ADDR_W  load/store write address
ldst__memc__write_data  input  DATA_W  load/store write data
ldst__memc__read_valid  input  1  load/store read
ldst__memc__read_address  input  ADDR_W  load/store read address
memc__ldst__read_data  output  DATA_W  load/store read data
memc__ldst__read_data_valid  output  1  load/store read valid
sram_en  output  1  SRAM access enable
sram_we  output  1  SRAM write enable
sram_addr  output  ADDR_W  SRAM address
sram_wdata  output  DATA_W  SRAM write data
sram_rdata  input  DATA_W  SRAM read data, valid RD_LAT cycles after sram_en & !sram_we

Behaviour:
- Reset (reset_poweron low, asynchronous):
  - all outputs 0; state DMA_OWN; rr_last = READ (write has priority first); tag pipe cleared.
  - In-flight reads are discarded, with no data_valid pulses after reset.
- States:
  - DMA_OWN: one access per cycle.
    - Write candidate = write_valid. Read candidate = read_valid & !read_pause.
    - If both, the side not equal to rr_last wins, and rr_last updates to the winner.
    - memc__dma__write_ready / read_ready are combinational grants: high only for the winner in the cycle it issues.
    - If ldst__memc__request is high, no DMA grant is given and the state goes to DRAIN_IN.
  - DRAIN_IN: no issues. Move to LDST_OWN the cycle after the read tag pipe is empty.
  - LDST_OWN: memc__ldst__granted = 1 (registered).
    - ldst write_valid issues a write; read_valid issues a read.
    - If both are high, the write executes and the read is ignored.
    - ldst__memc__released high, or request low, moves to DRAIN_OUT. The access presented in that cycle is still executed.
  - DRAIN_OUT: granted drops to 0 on entry; no issues; wait until the tag pipe is empty, then go to DMA_OWN.
- Read return:
  - An RD_LAT-deep shift register carries {valid, owner} per issued read.
  - At the pipe output, sram_rdata is routed to memc__dma__read_data or memc__ldst__read_data, with the matching *_valid high for exactly one cycle.
  - The non-selected data output holds its last value.
- Latencies:
  - DMA read: accept at cycle N, data_valid at N+RD_LAT.
  - Write: SRAM write in the accept cycle (sram_* are combinational from the granted request).
- read_pause:
  - Blocks new read issue only. Already in-flight returns still appear; the DMA must absorb up to RD_LAT returns.
- Boundaries:
  - request asserted in the same cycle as a pending DMA access: ldst wins, and the DMA access is not granted.
  - released while in DRAIN_IN: ignored; the FSM still passes through LDST_OWN for at least one cycle.
  - Address wrap is the SRAM's responsibility; addresses pass unmodified.

Optional Feature:
- Macro: DMA_MEM_PORT_ARB_STATS_EN.
- When defined, adds three 32-bit saturating counters, cleared by reset, and output ports for each:
  - stat_dma_wr_cnt: DMA write grants
  - stat_dma_rd_cnt: DMA read grants
  - stat_ldst_stall_cnt: cycles in DRAIN_IN + DRAIN_OUT
- When undefined, the counters and ports are absent, and behaviour is otherwise identical.

Test Plan:
- DMA write valid alone, addr 0x000010, data 0xDEADBEEF -> write_ready=1 the same cycle; sram_we=1, sram_addr=0x10, sram_wdata=0xDEADBEEF.
- Continuous DMA write+read valid for 6 cycles -> grants alternate W,R,W,R,W,R; each read returns data exactly 2 cycles after its read_ready.
- Two DMA reads in flight, then ldst__memc__request raised -> no grants; granted=1 two cycles after the last return; first ldst read of addr 0x20 returns on memc__ldst__read_data_valid RD_LAT later.
- read_pause=1 with read_valid=1 for 5 cycles -> read_ready stays 0; earlier in-flight returns still delivered; writes continue to be granted.
- released pulse with a read in flight -> granted falls next cycle; DMA grants resume only after the ldst data_valid pulse.
- Assert reset_poweron low mid-read (1 in flight) -> all outputs 0 immediately; after release, no stray data_valid pulse; DMA write priority restored.
